wb_port_arbiter: RTL and testbench

Arbiter and sequencer for the single integer register-file write port at the writeback stage. Two producers compete for it: the execute path (ALU/CSR results, `exe_*`) and the memory path (load returns, `mem_*`). The block grants one producer per cycle and drives a registered write port. It also keeps a scoreboard of destination registers with loads in flight, which the decode-stage hazard logic reads.

---
 rtl/wb_port_arbiter.sv | 107 ++++++++++
 tb/tb_wb_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// ---------------
// Arbitrates the single integer register-file write port between the
// execute path (ALU/CSR results) and the memory path (load returns).
// Loads normally win. After the execute path has been denied for MAX_WAIT
// consecutive cycles it wins once. The selected result is registered onto
// the write port. A scoreboard of registers with loads in flight is kept
// for the decode-stage hazard logic.
//
// Ports:
//   clk, rst                          clock (rising edge), async active-high reset
//   exe_valid/exe_rd/exe_data         execute result request
//   exe_ready                         execute request granted this cycle
//   mem_valid/mem_rd/mem_data         load return request
//   mem_ready                         load return granted this cycle
//   ld_issue/ld_issue_rd              mark a register as awaiting a load
//   wb_en/wb_rd/wb_data               registered register-file write port
//   ld_pending                        registered scoreboard bitmap
module wb_port_arbiter #(
    parameter int XLEN     = 64,
    parameter int RF_AW    = 5,
    parameter int MAX_WAIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exe_valid,
    input  logic [RF_AW-1:0]      exe_rd,
    input  logic [XLEN-1:0]       exe_data,
    output logic                  exe_ready,
    input  logic                  mem_valid,
    input  logic [RF_AW-1:0]      mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    output logic                  mem_ready,
    input  logic                  ld_issue,
    input  logic [RF_AW-1:0]      ld_issue_rd,
    output logic                  wb_en,
    output logic [RF_AW-1:0]      wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic [2**RF_AW-1:0]   ld_pending
);

    localparam int SW = 2**RF_AW;
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    logic [CW-1:0]    starve_cnt;
    logic             force_exe;
    logic             transfer;
    logic [RF_AW-1:0] sel_rd;
    logic [XLEN-1:0]  sel_data;
    logic [SW-1:0]    pending_next;

    // Grant logic: memory has priority unless the execute path has waited
    // long enough, in which case it takes this cycle.
    always_comb begin
        force_exe = exe_valid && (starve_cnt == MAX_CNT);
        mem_ready = mem_valid && !force_exe;
        exe_ready = exe_valid && !mem_ready;
        transfer  = mem_ready || exe_ready;
        sel_rd    = mem_ready ? mem_rd   : exe_rd;
        sel_data  = mem_ready ? mem_data : exe_data;
    end

    // Scoreboard next state: the set is applied after the clear so that a
    // newer load to the same register keeps the bit pending. Index 0 is
    // never marked since x0 is never written.
    always_comb begin
        pending_next = ld_pending;
        if (mem_ready) begin
            pending_next[mem_rd] = 1'b0;
        end
        if (ld_issue && (ld_issue_rd != '0)) begin
            pending_next[ld_issue_rd] = 1'b1;
        end
    end

    // Starvation counter: counts consecutive denied execute cycles,
    // saturating at MAX_WAIT; any cycle without a waiting request resets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!exe_valid || exe_ready) begin
            starve_cnt <= '0;
        end else if (starve_cnt != MAX_CNT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Registered write port and scoreboard. Index and data only move on a
    // transfer; the enable alone marks the single valid cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            ld_pending <= '0;
        end else begin
            wb_en      <= transfer && (sel_rd != '0);
            ld_pending <= pending_next;
            if (transfer) begin
                wb_rd   <= sel_rd;
                wb_data <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
// ------------------
// Self-checking bench for wb_port_arbiter. Each cycle the expected grant
// is computed from a small reference model, the expected write-port
// contents are pushed to a queue, and they are popped and compared once
// the registered port updates. Directed scenarios add fixed expectations.
module tb_wb_port_arbiter;

    localparam int XLEN     = 64;
    localparam int RF_AW    = 5;
    localparam int MAX_WAIT = 3;

    logic             clk;
    logic             rst;
    logic             exe_valid;
    logic [RF_AW-1:0] exe_rd;
    logic [XLEN-1:0]  exe_data;
    logic             exe_ready;
    logic             mem_valid;
    logic [RF_AW-1:0] mem_rd;
    logic [XLEN-1:0]  mem_data;
    logic             mem_ready;
    logic             ld_issue;
    logic [RF_AW-1:0] ld_issue_rd;
    logic             wb_en;
    logic [RF_AW-1:0] wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic [31:0]      ld_pending;

    typedef struct packed {
        logic             en;
        logic [RF_AW-1:0] rd;
        logic [XLEN-1:0]  data;
    } wbExp_t;

    wbExp_t      expQ[$];
    int          vectorCount;
    int          missCount;
    int          tbStarve;
    logic [31:0] tbPend;
    logic        lastMem;
    logic        lastExe;

    wb_port_arbiter #(.XLEN(XLEN), .RF_AW(RF_AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .exe_valid(exe_valid), .exe_rd(exe_rd), .exe_data(exe_data), .exe_ready(exe_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .ld_pending(ld_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every comparison and reports misses.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectorCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs (called at posedge+1), checks the
    // combinational grants against the model, queues the expected write,
    // then after the edge pops and checks the write port and scoreboard.
    task automatic applyStimulus(input logic ev, input logic [RF_AW-1:0] erd, input logic [XLEN-1:0] ed,
                                 input logic mv, input logic [RF_AW-1:0] mrd, input logic [XLEN-1:0] md,
                                 input logic li, input logic [RF_AW-1:0] lrd);
        logic   em;
        logic   ee;
        wbExp_t e;
        wbExp_t got;
        exe_valid   = ev;  exe_rd = erd;  exe_data = ed;
        mem_valid   = mv;  mem_rd = mrd;  mem_data = md;
        ld_issue    = li;  ld_issue_rd = lrd;
        #3;
        em = mv && !(ev && (tbStarve == MAX_WAIT));
        ee = ev && !em;
        checkOutput("mem_ready", 64'(mem_ready), 64'(em));
        checkOutput("exe_ready", 64'(exe_ready), 64'(ee));
        e.en   = em || ee;
        e.rd   = em ? mrd : erd;
        e.data = em ? md  : ed;
        expQ.push_back(e);
        if (!ev || ee) tbStarve = 0;
        else if (tbStarve < MAX_WAIT) tbStarve++;
        if (em) tbPend[mrd] = 1'b0;
        if (li && (lrd != 0)) tbPend[lrd] = 1'b1;
        tbPend[0] = 1'b0;
        lastMem = em;
        lastExe = ee;
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checkOutput("queue_underflow", 64'd1, 64'd0);
        end else begin
            got = expQ.pop_front();
            checkOutput("wb_en", 64'(wb_en), 64'(got.en && (got.rd != 0)));
            if (got.en && (got.rd != 0)) begin
                checkOutput("wb_rd", 64'(wb_rd), 64'(got.rd));
                checkOutput("wb_data", wb_data, got.data);
            end
        end
        checkOutput("ld_pending", 64'(ld_pending), 64'(tbPend));
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    logic        memPat[8];
    logic [4:0]  rdPat[8];
    logic [31:0] pendBefore;

    initial begin
        vectorCount = 0;
        missCount   = 0;
        tbStarve    = 0;
        tbPend      = '0;
        memPat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        rdPat  = '{5'd2, 5'd2, 5'd2, 5'd1, 5'd2, 5'd2, 5'd2, 5'd1};
        rst = 1'b1;
        exe_valid = 1'b0; exe_rd = '0; exe_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        ld_issue = 1'b0; ld_issue_rd = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_wb_en", 64'(wb_en), 64'd0);
        checkOutput("rst_wb_rd", 64'(wb_rd), 64'd0);
        checkOutput("rst_wb_data", wb_data, 64'd0);
        checkOutput("rst_pending", 64'(ld_pending), 64'd0);
        checkOutput("rst_ready", 64'({exe_ready, mem_ready}), 64'd0);
        rst = 1'b0;

        // Single execute write, then the port drops again.
        applyStimulus(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, '0);
        checkOutput("single_rd", 64'(wb_rd), 64'd5);
        checkOutput("single_data", wb_data, 64'hDEAD_BEEF);
        idleCycle();
        checkOutput("single_en_drop", 64'(wb_en), 64'd0);

        // Contention: grants M,M,M,E repeating, write index lagging by one.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 5'd1, 64'(100 + i), 1'b1, 5'd2, 64'(200 + i), 1'b0, '0);
            checkOutput("grant_pattern", 64'(lastMem), 64'(memPat[i]));
            checkOutput("lag_rd", 64'(wb_rd), 64'(rdPat[i]));
        end
        idleCycle();

        // Scoreboard set, hold, clear.
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        checkOutput("bit7_set", 64'(ld_pending[7]), 64'd1);
        repeat (3) idleCycle();
        checkOutput("bit7_hold", 64'(ld_pending[7]), 64'd1);
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 64'h55, 1'b0, '0);
        checkOutput("bit7_clear", 64'(ld_pending[7]), 64'd0);
        checkOutput("ld_data", wb_data, 64'h55);

        // Same-cycle set and clear: set wins; a later return clears.
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 64'h99, 1'b1, 5'd9);
        checkOutput("bit9_collide", 64'(ld_pending[9]), 64'd1);
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 64'h9A, 1'b0, '0);
        checkOutput("bit9_clear", 64'(ld_pending[9]), 64'd0);

        // Write to x0 completes but does not enable the port; issue to x0 is ignored.
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd12);
        pendBefore = ld_pending;
        applyStimulus(1'b1, 5'd0, 64'h1234, 1'b0, '0, '0, 1'b1, 5'd0);
        checkOutput("x0_ready", 64'(lastExe), 64'd1);
        checkOutput("x0_wb_en", 64'(wb_en), 64'd0);
        checkOutput("x0_pending", 64'(ld_pending), 64'(pendBefore));

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end

        // Mid-cycle reset with a live write and a pending bit.
        applyStimulus(1'b1, 5'd6, 64'hABCD, 1'b0, '0, '0, 1'b1, 5'd4);
        checkOutput("pre_rst_en", 64'(wb_en), 64'd1);
        checkOutput("pre_rst_bit4", 64'(ld_pending[4]), 64'd1);
        exe_valid = 1'b0; mem_valid = 1'b0; ld_issue = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_wb_en", 64'(wb_en), 64'd0);
        checkOutput("async_wb_rd", 64'(wb_rd), 64'd0);
        checkOutput("async_wb_data", wb_data, 64'd0);
        checkOutput("async_pending", 64'(ld_pending), 64'd0);
        checkOutput("async_ready", 64'({exe_ready, mem_ready}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tbStarve = 0;
        tbPend   = '0;
        expQ.delete();

        // Post-reset sanity: counter restarted, so memory wins contention.
        applyStimulus(1'b1, 5'd3, 64'h33, 1'b1, 5'd8, 64'h88, 1'b0, '0);
        checkOutput("post_rst_grant", 64'(lastMem), 64'd1);
        idleCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
